// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control sequencer.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } sw_state_t;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 16;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stability-count debouncer and a
// registered single-cycle pulse on each accepted rising level.
module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             s;
    logic             db;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
            db    <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= raw;
            s     <= sync1;
            press <= 1'b0;
            if (s != db) begin
                if (cnt == CNT_LAST) begin
                    db    <= s;
                    cnt   <= '0;
                    press <= s & ~db;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                // Any return to the accepted level discards the partial count.
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: conditions the four buttons and runs the
// IDLE/RUN/PAUSED/DONE state machine driving run enable, clear and hold.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = 20,
    parameter bit          STOP_AT_WRAP    = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_pause,
    input  logic       btn_reset,
    input  logic       btn_lap,
    input  logic       overflow,
    output logic       run_en,
    output logic       clr,
    output logic       hold,
    output logic [1:0] state
);

    logic press_start;
    logic press_pause;
    logic press_reset;
    logic press_lap;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_start (
        .clk(clk), .rst(rst), .raw(btn_start), .press(press_start)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_pause (
        .clk(clk), .rst(rst), .raw(btn_pause), .press(press_pause)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_reset (
        .clk(clk), .rst(rst), .raw(btn_reset), .press(press_reset)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_lap (
        .clk(clk), .rst(rst), .raw(btn_lap), .press(press_lap)
    );

    sw_state_t state_q, state_d;
    logic      hold_q, hold_d;
    logic      clr_q, clr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= 1'b0;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            clr_q   <= clr_d;
        end
    end

    // Ignored presses fall through, so only the highest-priority effective one acts.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        clr_d   = 1'b0;
        if (press_reset) begin
            state_d = IDLE;
            clr_d   = 1'b1;
            hold_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (press_start) state_d = RUN;
                end
                RUN: begin
                    if (STOP_AT_WRAP && overflow) state_d = DONE;
                    else if (press_pause)         state_d = PAUSED;
                    else if (press_lap)           hold_d  = ~hold_q;
                end
                PAUSED: begin
                    if (press_start || press_pause) state_d = RUN;
                    else if (press_lap)             hold_d  = ~hold_q;
                end
                DONE: ;
                default: state_d = IDLE;
            endcase
        end
    end

    assign run_en = (state_q == RUN);
    assign clr    = clr_q;
    assign hold   = hold_q;
    assign state  = state_q;

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control sequencer for the two-digit BCD stopwatch datapath. It conditions four raw push-buttons (start, pause, reset, lap) with synchronisers, debouncers and edge detectors, then runs a small FSM. The FSM drives the counter's run enable, a one-cycle clear strobe and a display-hold (lap) flag. It sits between the board buttons and the BCD counter / LED blinker, and replaces ad-hoc button logic in the top level.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive stable cycles (after sync) needed to accept a button level change; the board top overrides it to about 10 ms of clk. Minimum 2.
- CNT_W, 20, width of each debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- STOP_AT_WRAP, 0, 1 = stop counting when the datapath signals overflow; 0 = keep counting through wrap.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- btn_start  input  1  raw start button, asynchronous, active-high
- btn_pause  input  1  raw pause/resume button, asynchronous, active-high
- btn_reset  input  1  raw clear button, asynchronous, active-high
- btn_lap  input  1  raw lap button, asynchronous, active-high
- overflow  input  1  one-cycle wrap pulse from the BCD counter (synchronous to clk)
- run_en  output  1  counter enable; high only in RUN
- clr  output  1  one-cycle clear strobe to the counter and LED blinker
- hold  output  1  freeze displayed value (lap); counting continues underneath
- state  output  2  current FSM state (for debug / LED)

Behaviour:
- rst (synchronous, active-high) forces every register to its reset value: state=IDLE, run_en=0, clr=0, hold=0, all sync flops 0, debounced levels 0, counters 0, press pulses 0. rst does not assert clr.
- Per-button conditioning, identical for all four buttons:
  - 2-FF synchroniser produces s.
  - If s != db, the counter increments each cycle. When the counter equals DEBOUNCE_CYCLES-1 and s != db still holds, db <= s and the counter <= 0.
  - If s == db, the counter <= 0, so a glitch shorter than DEBOUNCE_CYCLES cycles is fully discarded.
  - press <= (s & ~db) at the update edge only: a registered, single-cycle pulse on rising edges of db. No pulse on release.
  - Latency: a raw input that rises before edge 1 and stays high gives press=1 during the cycle after edge DEBOUNCE_CYCLES+2, for exactly 1 cycle. A held button never repeats.
- FSM states (package encoding): IDLE=0, RUN=1, PAUSED=2, DONE=3. Transitions are evaluated on press pulses. Priority when presses coincide: reset > start > pause > lap.
  - Any state, reset press: go to IDLE, clr=1 for exactly the next cycle, hold <= 0.
  - IDLE: start goes to RUN. pause and lap are ignored.
  - RUN: pause goes to PAUSED. start is ignored. lap toggles hold. If overflow=1 and STOP_AT_WRAP=1, go to DONE; overflow has higher priority than pause in the same cycle. If STOP_AT_WRAP=0, overflow is ignored.
  - PAUSED: pause or start goes to RUN. lap toggles hold.
  - DONE: only reset leaves. Start, pause and lap are ignored; hold is kept.
- Outputs are Moore, decoded from the state register: run_en = (state==RUN). clr and hold are registered. No combinational path from inputs to outputs.
- Overflow in any state other than RUN is ignored.
- rst during a debounce count: the partial count is lost and no pulse is produced for that press.

Decomposition:
- Package stopwatch_pkg holds:
  - state encodings IDLE/RUN/PAUSED/DONE (2-bit);
  - a default-debounce constant.
- One sub-module, btn_debounce (sync + debounce + rising-edge pulse; params DEBOUNCE_CYCLES, CNT_W; ports clk, rst, raw, press). It is instantiated 4 times.
- The FSM and output registers stay in stopwatch_ctrl.

Test Plan (DEBOUNCE_CYCLES=4 unless noted):
- btn_start high for 10 cycles from IDLE -> internal start press is high only in the cycle after edge 6; state=RUN and run_en=1 from the following cycle; clr stays 0.
- btn_pause high for 3 cycles, then low, while in RUN -> no press; state stays RUN, run_en=1.
- In RUN, clean pause press -> state=PAUSED, run_en=0; a second pause press -> RUN, run_en=1; a start press while in RUN -> no change.
- btn_reset and btn_start rise in the same cycle from RUN -> state=IDLE, clr=1 for exactly 1 cycle, run_en=0, hold=0.
- STOP_AT_WRAP=1, in RUN, overflow pulse -> state=DONE (3), run_en=0. Start and pause presses -> no change. Reset press -> IDLE with a one-cycle clr. Repeat with STOP_AT_WRAP=0 -> state stays RUN.
- Lap press in RUN -> hold=1 while run_en stays 1. A second lap press -> hold=0. Assert rst for 1 cycle at debounce count 2 of a lap press -> no hold change; all outputs at reset values.
